// File: rtl/micro_core_param.sv
// micro_core_param
// Single-clock accumulator micro-core. A small program memory is loaded
// through a write port while the core is halted; a FETCH/EXEC state machine
// then runs the program, one state change per step tick. The step tick is a
// clock enable produced by an internal divider, so every register runs on clk.
//
// Ports
//   clk         system clock
//   iReset      synchronous active-high reset
//   iRun        pulse; starts execution at PC=0 when halted
//   iProgWe     program write strobe (honoured only while halted)
//   iProgAddr   program write address
//   iProgData   instruction {opcode[3:0], operand[DATA_W-1:0]}
//   iInputData  external input port, read by LDIN
//   oContador   current program counter
//   oData       output register, written by OUT
//   oLED        OR-reduction of oData
//   oFlags      {V,N,C,Z}
//   oHalted     1 while the core is idle
//   oStep       one-clk pulse per step tick
module micro_core_param #(
  parameter  int DATA_W     = 4,
  parameter  int PROG_DEPTH = 16,
  parameter  int DIV        = 1,
  localparam int PC_W       = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = 4 + DATA_W
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               iRun,
  input  logic               iProgWe,
  input  logic [PC_W-1:0]    iProgAddr,
  input  logic [INSTR_W-1:0] iProgData,
  input  logic [DATA_W-1:0]  iInputData,
  output logic [PC_W-1:0]    oContador,
  output logic [DATA_W-1:0]  oData,
  output logic               oLED,
  output logic [3:0]         oFlags,
  output logic               oHalted,
  output logic               oStep
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_LDIN = 4'h2, OP_ADD  = 4'h3,
    OP_SUB  = 4'h4, OP_AND  = 4'h5, OP_OR   = 4'h6, OP_XOR  = 4'h7,
    OP_NOT  = 4'h8, OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_JMP  = 4'hB,
    OP_JZ   = 4'hC, OP_JC   = 4'hD, OP_OUT  = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  // A one-bit counter is kept even for DIV=1 so the divider logic has a
  // single shape; with DIV=1 it simply wraps every cycle.
  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    divCnt_q;
  logic                step_q;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   data_q;

  opcode_t             opcode;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   res;
  logic                carryNew;
  logic                ovfNew;
  logic                updZN;
  logic                updCV;
  logic                jumpTaken;

  assign opcode  = opcode_t'(ir_q[INSTR_W-1 -: 4]);
  assign operand = ir_q[DATA_W-1:0];

  // Step tick generator. The pulse is registered so it appears one cycle
  // after the counter reaches its last value, which keeps it low during the
  // reset cycle and high on every following cycle when DIV=1.
  always_ff @(posedge clk) begin
    if (iReset) begin
      divCnt_q <= '0;
      step_q   <= 1'b0;
    end else if (divCnt_q == DIV_LAST) begin
      divCnt_q <= '0;
      step_q   <= 1'b1;
    end else begin
      divCnt_q <= divCnt_q + DIV_W'(1);
      step_q   <= 1'b0;
    end
  end

  // Program memory. It has no reset so a program survives a core reset;
  // writes are accepted only while idle so a running program cannot be
  // modified underneath itself.
  always_ff @(posedge clk) begin
    if (iProgWe && (state_q == IDLE)) begin
      mem[iProgAddr] <= iProgData;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Leaving IDLE reacts to iRun immediately; every other
  // transition waits for a step tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iRun)   state_d = FETCH;
      FETCH:   if (step_q) state_d = EXEC;
      EXEC:    if (step_q) state_d = (opcode == OP_HALT) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    oHalted = (state_q == IDLE);
  end

  // ALU and flag computation for the instruction held in IR. Carry and
  // overflow are taken from a one-bit-wider add/subtract; for subtraction
  // the extra bit is the borrow, set exactly when A < operand unsigned.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, operand};
    diff     = {1'b0, acc_q} - {1'b0, operand};
    res      = acc_q;
    carryNew = flags_q[1];
    ovfNew   = flags_q[3];
    updZN    = 1'b0;
    updCV    = 1'b0;
    case (opcode)
      OP_LDI:  begin res = operand;    updZN = 1'b1; end
      OP_LDIN: begin res = iInputData; updZN = 1'b1; end
      OP_ADD: begin
        res      = sum[DATA_W-1:0];
        carryNew = sum[DATA_W];
        ovfNew   = (acc_q[DATA_W-1] == operand[DATA_W-1]) &&
                   (res[DATA_W-1] != acc_q[DATA_W-1]);
        updZN    = 1'b1;
        updCV    = 1'b1;
      end
      OP_SUB: begin
        res      = diff[DATA_W-1:0];
        carryNew = diff[DATA_W];
        ovfNew   = (acc_q[DATA_W-1] != operand[DATA_W-1]) &&
                   (res[DATA_W-1] != acc_q[DATA_W-1]);
        updZN    = 1'b1;
        updCV    = 1'b1;
      end
      OP_AND: begin res = acc_q & operand; carryNew = 1'b0; ovfNew = 1'b0; updZN = 1'b1; updCV = 1'b1; end
      OP_OR:  begin res = acc_q | operand; carryNew = 1'b0; ovfNew = 1'b0; updZN = 1'b1; updCV = 1'b1; end
      OP_XOR: begin res = acc_q ^ operand; carryNew = 1'b0; ovfNew = 1'b0; updZN = 1'b1; updCV = 1'b1; end
      OP_NOT: begin res = ~acc_q;          carryNew = 1'b0; ovfNew = 1'b0; updZN = 1'b1; updCV = 1'b1; end
      OP_SHL: begin
        res      = {acc_q[DATA_W-2:0], 1'b0};
        carryNew = acc_q[DATA_W-1];
        ovfNew   = 1'b0;
        updZN    = 1'b1;
        updCV    = 1'b1;
      end
      OP_SHR: begin
        res      = {1'b0, acc_q[DATA_W-1:1]};
        carryNew = acc_q[0];
        ovfNew   = 1'b0;
        updZN    = 1'b1;
        updCV    = 1'b1;
      end
      default: ;
    endcase
  end

  // Next accumulator, flags and PC. Flags outside the ALU group hold, and a
  // HALT parks the PC on its own address so oContador shows where it stopped.
  always_comb begin
    acc_d     = updZN ? res : acc_q;
    flags_d   = flags_q;
    if (updZN) begin
      flags_d[0] = (res == '0);
      flags_d[2] = res[DATA_W-1];
    end
    if (updCV) begin
      flags_d[1] = carryNew;
      flags_d[3] = ovfNew;
    end
    jumpTaken = (opcode == OP_JMP) ||
                ((opcode == OP_JZ) && flags_q[0]) ||
                ((opcode == OP_JC) && flags_q[1]);
    if (jumpTaken) begin
      pc_d = PC_W'(operand);
    end else if (opcode == OP_HALT) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // Architectural registers. Everything commits in a single EXEC tick, so a
  // reset arriving mid-instruction leaves nothing half-updated.
  always_ff @(posedge clk) begin
    if (iReset) begin
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (iRun) pc_q <= '0;
        FETCH: if (step_q) ir_q <= mem[pc_q];
        EXEC: if (step_q) begin
          acc_q   <= acc_d;
          flags_q <= flags_d;
          pc_q    <= pc_d;
          if (opcode == OP_OUT) data_q <= acc_q;
        end
        default: ;
      endcase
    end
  end

  assign oContador = pc_q;
  assign oData     = data_q;
  assign oLED      = |data_q;
  assign oFlags    = flags_q;
  assign oStep     = step_q;

endmodule
